// File: rtl/pontuacao_pkg.sv
// pontuacao_pkg: shared constants and types for the scoring stage.
//   N_LANES       number of pattern lanes feeding the scorer
//   PEND_W        width of the pending-hit counter
//   COMBO_STEP    consecutive hits per multiplier step
//   MULT_MAX      multiplier ceiling
//   SCORE_MAX_BCD saturated 5-digit BCD score
package pontuacao_pkg;

  localparam int N_LANES    = 3;
  localparam int PEND_W     = 4;
  localparam int COMBO_STEP = 10;
  localparam int MULT_MAX   = 4;

  localparam logic [19:0] SCORE_MAX_BCD = 20'h99999;
  localparam int          N_DIGITS      = 5;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/pontuacao_bcd_add5.sv
// bcd_add5: combinational 5-digit packed-BCD adder with a small binary
// addend (0..7), saturating to 99999 on overflow.
//   score   in  20  packed BCD operand, digit 4 in [19:16]
//   addend  in  3   binary value to add
//   result  out 20  packed BCD sum, or 0x99999 when it would overflow
module bcd_add5
  import pontuacao_pkg::*;
(
  input  logic [19:0] score,
  input  logic [2:0]  addend,
  output logic [19:0] result
);

  logic [3:0]  carry;
  logic [4:0]  dsum;
  logic [4:0]  dadj;
  bcd_digit_t  digit;
  logic [19:0] raw;

  // Ripple through the digits. The addend enters at digit 0 as the initial
  // "carry"; after that the carry is 0 or 1. Adding 6 to a digit sum above 9
  // leaves the corrected digit in the low nibble.
  always_comb begin
    carry = {1'b0, addend};
    dsum  = '0;
    dadj  = '0;
    digit = '0;
    raw   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      dsum = {1'b0, score[i*4 +: 4]} + {1'b0, carry};
      dadj = dsum + 5'd6;
      if (dsum > 5'd9) begin
        digit = dadj[3:0];
        carry = 4'd1;
      end else begin
        digit = dsum[3:0];
        carry = 4'd0;
      end
      raw[i*4 +: 4] = digit;
    end
    // A carry out of the top digit means the true sum passed 99999.
    result = (carry != 4'd0) ? SCORE_MAX_BCD : raw;
  end

endmodule

// File: rtl/pontuacao.sv
// pontuacao: scoring stage behind the pattern lanes. Rising edges on ponto
// are queued in a saturating pending counter and credited one per cycle with
// a combo-based multiplier into a 5-digit BCD score; rising edges on erro
// break the combo and flush the queue. fim_de_jogo freezes all scoring.
//   CLOCK_25       in  1        clock, rising edge
//   reset          in  1        async reset, active low
//   ponto          in  N_LANES  per-lane hit strobe (rising edge counts)
//   erro           in  N_LANES  per-lane miss strobe (rising edge counts)
//   fim_de_jogo    in  1        freeze scoring while high
//   display        out 20       packed BCD score
//   combo          out 8        consecutive-hit count, saturating
//   multiplicador  out 3        current multiplier 1..MULT_MAX
//   max_combo      out 8        highest combo since reset
//   ocupado        out 1        pending hits remain
module pontuacao #(
  parameter int N_LANES    = pontuacao_pkg::N_LANES,
  parameter int PEND_W     = pontuacao_pkg::PEND_W,
  parameter int COMBO_STEP = pontuacao_pkg::COMBO_STEP,
  parameter int MULT_MAX   = pontuacao_pkg::MULT_MAX
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic [N_LANES-1:0] ponto,
  input  logic [N_LANES-1:0] erro,
  input  logic               fim_de_jogo,
  output logic [19:0]        display,
  output logic [7:0]         combo,
  output logic [2:0]         multiplicador,
  output logic [7:0]         max_combo,
  output logic               ocupado
);

  // Two spare bits let pend + edges be formed without wrapping before the
  // saturation compare.
  localparam int              CNT_W    = PEND_W + 2;
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'((1 << PEND_W) - 1);

  logic [N_LANES-1:0] ponto_q, erro_q;
  logic [PEND_W-1:0]  pend_q,  pend_d;
  logic [19:0]        score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic [7:0]         max_q,   max_d;

  logic [N_LANES-1:0] hit_rise;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   pend_sum;
  logic               miss_any;
  logic               consume;
  logic [2:0]         mult;
  logic [7:0]         combo_inc;
  logic [19:0]        score_add;

  // Edge detection
  assign hit_rise = ponto & ~ponto_q;
  assign miss_any = |(erro & ~erro_q);

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_LANES; i++)
      hit_cnt = hit_cnt + CNT_W'(hit_rise[i]);
  end

  // Multiplier from the registered combo: one step for every COMBO_STEP
  // threshold passed, capped at MULT_MAX.
  always_comb begin
    mult = 3'd1;
    for (int i = 1; i < MULT_MAX; i++)
      if (int'(combo_q) >= COMBO_STEP * i) mult = mult + 3'd1;
  end

  assign consume   = (pend_q != '0) && !fim_de_jogo;
  assign combo_inc = (combo_q == 8'hff) ? 8'hff : combo_q + 8'd1;

  bcd_add5 u_add (
    .score  (score_q),
    .addend (mult),
    .result (score_add)
  );

  // consume can only be set when pend_q >= 1, so the subtraction never
  // underflows.
  assign pend_sum = CNT_W'(pend_q) - CNT_W'(consume) + hit_cnt;

  always_comb begin
    pend_d  = pend_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    if (!fim_de_jogo) begin
      if (consume) begin
        // The credited hit uses the pre-miss multiplier even if a miss
        // lands in the same cycle; only the combo is then cleared.
        score_d = score_add;
        combo_d = combo_inc;
        if (combo_inc > max_q) max_d = combo_inc;
      end
      if (miss_any) begin
        combo_d = '0;
        pend_d  = '0;
      end else if (pend_sum > PEND_MAX) begin
        pend_d = PEND_MAX[PEND_W-1:0];
      end else begin
        pend_d = pend_sum[PEND_W-1:0];
      end
    end
  end

  // Edge registers track the inputs even while frozen, so edges that occur
  // during fim_de_jogo are not replayed afterwards.
  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      ponto_q <= '0;
      erro_q  <= '0;
      pend_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
    end else begin
      ponto_q <= ponto;
      erro_q  <= erro;
      pend_q  <= pend_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  assign display       = score_q;
  assign combo         = combo_q;
  assign multiplicador = mult;
  assign max_combo     = max_q;
  assign ocupado       = (pend_q != '0);

endmodule
